// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width and the
// control-strobe bundle layout used by the control unit, datapath and generator.
package mult_pkg;

    localparam int MULT_N  = 4;
    localparam int MULT_PW = 2 * MULT_N;

    // Strobe order on the wire from the control unit: {carga_q, reset_a, carga_a, desplaza_q, fin}
    typedef struct packed {
        logic carga_q;
        logic reset_a;
        logic carga_a;
        logic desplaza_q;
        logic fin;
    } ctrl_t;

endpackage

// File: rtl/mult_if.sv
// Bundle between the multiplier control/consumer side (master) and the datapath (slave).
interface mult_if
    import mult_pkg::*;
#(
    parameter int N = MULT_N
);
    logic [N-1:0]   op_m;
    logic [N-1:0]   op_q;
    logic           carga_q;
    logic           reset_a;
    logic           carga_a;
    logic           desplaza_q;
    logic           fin;
    logic           q0;
    logic           busy;
    logic [2*N-1:0] res;
    logic           res_valid;
    logic           res_ready;
    logic           err;

    modport master (
        output op_m, op_q, carga_q, reset_a, carga_a, desplaza_q, fin, res_ready,
        input  q0, busy, res, res_valid, err
    );

    modport slave (
        input  op_m, op_q, carga_q, reset_a, carga_a, desplaza_q, fin, res_ready,
        output q0, busy, res, res_valid, err
    );
endinterface

// File: rtl/mult_result_buf.sv
// Product register with a valid/ready handshake toward the consumer; a capture that
// arrives while an unaccepted product is held is dropped and flagged as overrun.
module mult_result_buf
    import mult_pkg::*;
#(
    parameter int W = MULT_PW
)(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         capture_i,
    input  logic [W-1:0] prod_i,
    input  logic         ready_i,
    output logic [W-1:0] res_o,
    output logic         valid_o,
    output logic         errOvr_o
);

    logic [W-1:0] res_q, res_d;
    logic         valid_q, valid_d;
    logic         errOvr_q, errOvr_d;

    always_comb begin
        res_d    = res_q;
        valid_d  = valid_q;
        errOvr_d = errOvr_q;
        if (capture_i) begin
            // The slot is free if empty or being drained on this very edge
            if (!valid_q || ready_i) begin
                res_d   = prod_i;
                valid_d = 1'b1;
            end else begin
                errOvr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_q    <= '0;
            valid_q  <= 1'b0;
            errOvr_q <= 1'b0;
        end else begin
            res_q    <= res_d;
            valid_q  <= valid_d;
            errOvr_q <= errOvr_d;
        end
    end

    assign res_o    = res_q;
    assign valid_o  = valid_q;
    assign errOvr_o = errOvr_q;

endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath: M, C:A, Q registers driven by the control-unit
// strobes, a step counter guarding against extra shifts, and the product buffer.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int N = MULT_N
)(
    input  logic  clk,
    input  logic  reset_n,
    mult_if.slave bus
);

    localparam int CW = $clog2(N + 1);

    ctrl_t          ctrl;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   q_q, q_d;
    logic           c_q, c_d;
    logic [CW-1:0]  stepCnt_q, stepCnt_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [N:0]     sum;
    logic [N:0]     ca;
    logic [N-1:0]   qShift;
    logic           shiftCounted;
    logic           capture;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] bufRes;
    logic           bufValid;
    logic           errOvr;

    assign ctrl = {bus.carga_q, bus.reset_a, bus.carga_a, bus.desplaza_q, bus.fin};

    always_comb begin
        sum = {1'b0, a_q} + {1'b0, m_q};
        if (ctrl.reset_a)      ca = '0;
        else if (ctrl.carga_a) ca = sum;
        else                   ca = {c_q, a_q};

        // A same-cycle add feeds straight into the shift, so one cycle can do a full step
        if (ctrl.desplaza_q) begin
            c_d    = 1'b0;
            a_d    = ca[N:1];
            qShift = {ca[0], q_q[N-1:1]};
        end else begin
            c_d    = ca[N];
            a_d    = ca[N-1:0];
            qShift = q_q;
        end
        m_d = ctrl.carga_q ? bus.op_m : m_q;
        q_d = ctrl.carga_q ? bus.op_q : qShift;

        shiftCounted = ctrl.desplaza_q && busy_q && !ctrl.carga_q;
        capture      = ctrl.fin && busy_q;
        prod         = {a_d, qShift};

        stepCnt_d = stepCnt_q;
        err_d     = err_q;
        if (ctrl.carga_q) begin
            stepCnt_d = '0;
        end else if (shiftCounted) begin
            if (stepCnt_q == CW'(N)) err_d = 1'b1;
            else                     stepCnt_d = stepCnt_q + CW'(1);
        end
        if (ctrl.fin && !busy_q) err_d = 1'b1;

        busy_d = busy_q;
        if (ctrl.carga_q)  busy_d = 1'b1;
        else if (ctrl.fin) busy_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            stepCnt_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            c_q       <= c_d;
            stepCnt_q <= stepCnt_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    mult_result_buf #(.W(2 * N)) u_resBuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .capture_i (capture),
        .prod_i    (prod),
        .ready_i   (bus.res_ready),
        .res_o     (bufRes),
        .valid_o   (bufValid),
        .errOvr_o  (errOvr)
    );

    assign bus.q0        = q_q[0];
    assign bus.busy      = busy_q;
    assign bus.res       = bufRes;
    assign bus.res_valid = bufValid;
    assign bus.err       = err_q | errOvr;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: a table of full multiplies plus hand sequences
// for reset, result overrun, excess shifts and a stray fin.
module tb_mult_datapath;
    import mult_pkg::*;

    localparam int N = MULT_N;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    mult_if #(.N(N)) bus();

    mult_datapath #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        bit             combined;
        logic [2*N-1:0] prod;
    } vec_t;

    vec_t vecs[7];

    function automatic ctrl_t mk(input bit cq, input bit ra, input bit ca, input bit dq, input bit fn);
        return ctrl_t'({cq, ra, ca, dq, fn});
    endfunction

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of strobes/operands, then settle just past the rising edge
    task automatic applyStimulus(input ctrl_t c, input logic [N-1:0] m, input logic [N-1:0] q, input logic rdy);
        bus.carga_q    = c.carga_q;
        bus.reset_a    = c.reset_a;
        bus.carga_a    = c.carga_a;
        bus.desplaza_q = c.desplaza_q;
        bus.fin        = c.fin;
        bus.op_m       = m;
        bus.op_q       = q;
        bus.res_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(mk(0, 0, 0, 0, 0), '0, '0, rdy);
    endtask

    task automatic resetPulse();
        reset_n = 1'b0;
        idle(1'b0);
        reset_n = 1'b1;
    endtask

    // Full multiply: load with accumulator clear, N steps driven by the known multiplier bits, then fin
    task automatic runProduct(input logic [N-1:0] m, input logic [N-1:0] q, input bit combined,
                              input logic rdy, input string tag);
        applyStimulus(mk(1, 1, 0, 0, 0), m, q, rdy);
        checkOutput({tag, "_busy_load"}, {15'd0, bus.busy}, 16'd1);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("%s_q0_step%0d", tag, i), {15'd0, bus.q0}, {15'd0, q[i]});
            if (combined) begin
                applyStimulus(mk(0, 0, q[i], 1, 0), m, q, rdy);
            end else begin
                applyStimulus(mk(0, 0, q[i], 0, 0), m, q, rdy);
                applyStimulus(mk(0, 0, 0, 1, 0), m, q, rdy);
            end
        end
        applyStimulus(mk(0, 0, 0, 0, 1), m, q, rdy);
    endtask

    initial begin
        vecs[0] = '{m: 4'd5,  q: 4'd3,  combined: 1'b0, prod: 8'd15};
        vecs[1] = '{m: 4'd15, q: 4'd15, combined: 1'b0, prod: 8'd225};
        vecs[2] = '{m: 4'd7,  q: 4'd6,  combined: 1'b1, prod: 8'd42};
        vecs[3] = '{m: 4'd7,  q: 4'd6,  combined: 1'b0, prod: 8'd42};
        vecs[4] = '{m: 4'd0,  q: 4'd13, combined: 1'b1, prod: 8'd0};
        vecs[5] = '{m: 4'd15, q: 4'd15, combined: 1'b1, prod: 8'd225};
        vecs[6] = '{m: 4'd12, q: 4'd10, combined: 1'b1, prod: 8'd120};

        reset_n        = 1'b1;
        bus.carga_q    = 1'b0;
        bus.reset_a    = 1'b0;
        bus.carga_a    = 1'b0;
        bus.desplaza_q = 1'b0;
        bus.fin        = 1'b0;
        bus.op_m       = '0;
        bus.op_q       = '0;
        bus.res_ready  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_res",   {8'd0, bus.res},        16'd0);
        checkOutput("rst_valid", {15'd0, bus.res_valid}, 16'd0);
        checkOutput("rst_busy",  {15'd0, bus.busy},      16'd0);
        checkOutput("rst_err",   {15'd0, bus.err},       16'd0);
        checkOutput("rst_q0",    {15'd0, bus.q0},        16'd0);
        idle(1'b0);
        reset_n = 1'b1;
        idle(1'b0);

        for (int v = 0; v < 7; v++) begin
            runProduct(vecs[v].m, vecs[v].q, vecs[v].combined, 1'b1, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_res", v),   {8'd0, bus.res},        {8'd0, vecs[v].prod});
            checkOutput($sformatf("vec%0d_valid", v), {15'd0, bus.res_valid}, 16'd1);
            checkOutput($sformatf("vec%0d_busy", v),  {15'd0, bus.busy},      16'd0);
            idle(1'b1);
            checkOutput($sformatf("vec%0d_valid_drop", v), {15'd0, bus.res_valid}, 16'd0);
        end
        checkOutput("table_err", {15'd0, bus.err}, 16'd0);

        // Async reset two steps into 5 x 7; q0 is 1 at that point
        applyStimulus(mk(1, 1, 0, 0, 0), 4'd5, 4'd7, 1'b0);
        applyStimulus(mk(0, 0, 1, 1, 0), 4'd5, 4'd7, 1'b0);
        applyStimulus(mk(0, 0, 1, 1, 0), 4'd5, 4'd7, 1'b0);
        checkOutput("midop_q0_before", {15'd0, bus.q0}, 16'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midop_q0",    {15'd0, bus.q0},        16'd0);
        checkOutput("midop_busy",  {15'd0, bus.busy},      16'd0);
        checkOutput("midop_res",   {8'd0, bus.res},        16'd0);
        checkOutput("midop_valid", {15'd0, bus.res_valid}, 16'd0);
        checkOutput("midop_err",   {15'd0, bus.err},       16'd0);
        idle(1'b0);
        reset_n = 1'b1;
        idle(1'b0);
        idle(1'b0);
        checkOutput("midop_valid_after", {15'd0, bus.res_valid}, 16'd0);
        checkOutput("midop_busy_after",  {15'd0, bus.busy},      16'd0);

        // Overrun: second product finishes while the first is still unaccepted
        runProduct(4'd5, 4'd3, 1'b1, 1'b0, "ovr1");
        checkOutput("ovr1_res",   {8'd0, bus.res},        16'd15);
        checkOutput("ovr1_valid", {15'd0, bus.res_valid}, 16'd1);
        checkOutput("ovr1_err",   {15'd0, bus.err},       16'd0);
        runProduct(4'd7, 4'd6, 1'b1, 1'b0, "ovr2");
        checkOutput("ovr2_res",   {8'd0, bus.res},        16'd15);
        checkOutput("ovr2_valid", {15'd0, bus.res_valid}, 16'd1);
        checkOutput("ovr2_err",   {15'd0, bus.err},       16'd1);
        idle(1'b1);
        checkOutput("ovr_drain_valid", {15'd0, bus.res_valid}, 16'd0);
        checkOutput("ovr_drain_res",   {8'd0, bus.res},        16'd15);

        // Fifth shift while busy trips the step-count guard
        resetPulse();
        checkOutput("xs_err_cleared", {15'd0, bus.err}, 16'd0);
        applyStimulus(mk(1, 1, 0, 0, 0), 4'd5, 4'd3, 1'b0);
        for (int i = 0; i < N; i++) applyStimulus(mk(0, 0, 0, 1, 0), 4'd5, 4'd3, 1'b0);
        checkOutput("xs_err_after4", {15'd0, bus.err}, 16'd0);
        applyStimulus(mk(0, 0, 0, 1, 0), 4'd5, 4'd3, 1'b0);
        checkOutput("xs_err_after5", {15'd0, bus.err},  16'd1);
        checkOutput("xs_busy",       {15'd0, bus.busy}, 16'd1);

        // fin with nothing in progress must not touch the held product
        resetPulse();
        runProduct(4'd5, 4'd3, 1'b1, 1'b0, "idlefin");
        checkOutput("idlefin_pre_err", {15'd0, bus.err}, 16'd0);
        applyStimulus(mk(0, 0, 0, 0, 1), 4'd9, 4'd9, 1'b0);
        checkOutput("idlefin_err",   {15'd0, bus.err},       16'd1);
        checkOutput("idlefin_res",   {8'd0, bus.res},        16'd15);
        checkOutput("idlefin_valid", {15'd0, bus.res_valid}, 16'd1);
        checkOutput("idlefin_busy",  {15'd0, bus.busy},      16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
